// File: rtl/crack_sequencer.sv
// Host-link to NT-hash cracker controller: packs host bytes into hashes, replays them
// into the cracker hash store with a setup/strobe/gap cadence, launches and streams results.
//
// state  | meaning
// IDLE   | accept host bytes or a start request
// SETUP  | new_hash_byte presented, before strobe
// STROBE | store_hash_byte high
// GAP    | byte held after strobe; byte/hash counters advance
// LAUNCH | search go is issued in the following cycle
// RUN    | waiting for the cracker's your_turn
// EMIT   | password byte offered to host
// ACK    | go pulse out, cracker advances to next password byte
// DONE   | search finished; outputs hold until start
module crack_sequencer #(
   parameter int MAX_HASHES = 128,
   parameter int HASH_BYTES = 16
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] host_byte,
   input  logic       host_valid,
   output logic       host_ready,
   input  logic       start,
   output logic [7:0] new_hash_byte,
   output logic       store_hash_byte,
   output logic       go,
   input  logic       your_turn,
   input  logic       match_found,
   input  logic [7:0] password_byte,
   output logic [7:0] result_byte,
   output logic       result_valid,
   input  logic       result_ready,
   output logic [7:0] hash_count,
   output logic       busy,
   output logic       found,
   output logic       error
);

   localparam int BW = $clog2(HASH_BYTES);
   localparam logic [BW-1:0] LAST_BYTE = BW'(HASH_BYTES - 1);
   localparam logic [7:0] MAX_CNT = 8'(MAX_HASHES);

   typedef enum logic [3:0] {
      IDLE, SETUP, STROBE, GAP, LAUNCH, RUN, EMIT, ACK, DONE
   } state_t;

   state_t state, state_n;
   logic [BW-1:0] byte_cnt, byte_cnt_n;
   logic [7:0] hash_count_n;
   logic found_n, error_n;
   logic accept, handshake;

   // host_ready is a flop, so a same-cycle start is masked here instead
   assign accept    = (state == IDLE) && host_valid && host_ready && !start;
   assign handshake = (state == EMIT) && result_valid && result_ready;

   always_comb begin
      state_n      = state;
      byte_cnt_n   = byte_cnt;
      hash_count_n = hash_count;
      found_n      = found;
      error_n      = error;
      case (state)
         IDLE: begin
            if (start) begin
               if (byte_cnt != '0 || hash_count == '0) error_n = 1'b1;
               else                                    state_n = LAUNCH;
            end else if (accept) begin
               state_n = SETUP;
            end
         end
         SETUP:  state_n = STROBE;
         STROBE: state_n = GAP;
         GAP: begin
            state_n = IDLE;
            if (byte_cnt == LAST_BYTE) begin
               byte_cnt_n   = '0;
               hash_count_n = hash_count + 8'd1;
            end else begin
               byte_cnt_n = byte_cnt + 1'b1;
            end
         end
         LAUNCH: state_n = RUN;
         RUN: begin
            if (your_turn) state_n = match_found ? EMIT : DONE;
         end
         EMIT: begin
            if (handshake) begin
               if (result_byte == 8'h00) begin
                  found_n = 1'b1;
                  state_n = DONE;
               end else begin
                  state_n = ACK;
               end
            end
         end
         ACK: state_n = RUN;
         DONE: begin
            if (start) begin
               hash_count_n = '0;
               byte_cnt_n   = '0;
               found_n      = 1'b0;
               error_n      = 1'b0;
               state_n      = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state           <= IDLE;
         byte_cnt        <= '0;
         hash_count      <= '0;
         found           <= 1'b0;
         error           <= 1'b0;
         host_ready      <= 1'b0;
         new_hash_byte   <= '0;
         store_hash_byte <= 1'b0;
         go              <= 1'b0;
         result_byte     <= '0;
         result_valid    <= 1'b0;
         busy            <= 1'b0;
      end else begin
         state           <= state_n;
         byte_cnt        <= byte_cnt_n;
         hash_count      <= hash_count_n;
         found           <= found_n;
         error           <= error_n;
         host_ready      <= (state_n == IDLE) && (hash_count_n < MAX_CNT);
         store_hash_byte <= (state_n == STROBE);
         // launch go lags LAUNCH by a cycle; ACK go lands in the cycle after the handshake
         go              <= (state == LAUNCH) || (handshake && result_byte != 8'h00);
         result_valid    <= (state == EMIT) && !handshake;
         busy            <= !(state_n == IDLE || state_n == DONE);
         if (accept)
            new_hash_byte <= host_byte;
         if (state == RUN && your_turn && match_found)
            result_byte <= password_byte;
      end
   end

endmodule

// File: tb/tb_crack_sequencer.sv
// Directed bench for crack_sequencer: table-driven hash load plus hand-written
// sequences for launch, result streaming, errors, table-full and mid-operation reset.
module tb_crack_sequencer;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] host_byte = '0;
   logic       host_valid = 1'b0;
   logic       host_ready;
   logic       start = 1'b0;
   logic [7:0] new_hash_byte;
   logic       store_hash_byte;
   logic       go;
   logic       your_turn = 1'b0;
   logic       match_found = 1'b0;
   logic [7:0] password_byte = '0;
   logic [7:0] result_byte;
   logic       result_valid;
   logic       result_ready = 1'b1;
   logic [7:0] hash_count;
   logic       busy;
   logic       found;
   logic       error;

   crack_sequencer dut (
      .clk(clk), .reset_n(reset_n),
      .host_byte(host_byte), .host_valid(host_valid), .host_ready(host_ready),
      .start(start), .new_hash_byte(new_hash_byte), .store_hash_byte(store_hash_byte),
      .go(go), .your_turn(your_turn), .match_found(match_found),
      .password_byte(password_byte), .result_byte(result_byte),
      .result_valid(result_valid), .result_ready(result_ready),
      .hash_count(hash_count), .busy(busy), .found(found), .error(error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      logic [7:0] exp_count;
   } load_vec_t;

   load_vec_t tbl[16];

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int strobe_cnt = 0;
   int go_cnt = 0;
   int rv_cnt = 0;
   int last_strobe = -1;
   int gap_err = 0;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (store_hash_byte) begin
         if (last_strobe >= 0 && cyc - last_strobe != 4) gap_err++;
         last_strobe = cyc;
         strobe_cnt++;
      end
      if (go) go_cnt++;
      if (result_valid) rv_cnt++;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic wait_ready();
      int w = 0;
      while (!host_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk("ready_timeout", 32'(host_ready), 32'd1);
   endtask

   task automatic put_byte(input logic [7:0] b, input logic [7:0] exp_cnt);
      wait_ready();
      host_valid = 1'b1;
      host_byte  = b;
      @(negedge clk);
      host_valid = 1'b0;
      chk("setup_no_strobe", 32'(store_hash_byte), 32'd0);
      @(negedge clk);
      chk("strobe", 32'(store_hash_byte), 32'd1);
      chk("strobe_byte", 32'(new_hash_byte), 32'(b));
      @(negedge clk);
      chk("gap_no_strobe", 32'(store_hash_byte), 32'd0);
      chk("gap_byte", 32'(new_hash_byte), 32'(b));
      @(negedge clk);
      chk("hash_count", 32'(hash_count), 32'(exp_cnt));
   endtask

   task automatic load_table();
      for (int i = 0; i < 16; i++) put_byte(tbl[i].data, tbl[i].exp_count);
   endtask

   task automatic launch();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("go_lat1", 32'(go), 32'd0);
      chk("busy_launch", 32'(busy), 32'd1);
      @(negedge clk);
      chk("go_lat2", 32'(go), 32'd1);
      @(negedge clk);
      chk("go_single", 32'(go), 32'd0);
   endtask

   task automatic emit_one(input logic [7:0] pw);
      your_turn     = 1'b1;
      match_found   = 1'b1;
      password_byte = pw;
      @(negedge clk);
      your_turn   = 1'b0;
      match_found = 1'b0;
      chk("rv_lat1", 32'(result_valid), 32'd0);
      @(negedge clk);
      chk("rv_lat2", 32'(result_valid), 32'd1);
      chk("result_byte", 32'(result_byte), 32'(pw));
      @(negedge clk);
      chk("rv_drop", 32'(result_valid), 32'd0);
      chk("ack_go", 32'(go), (pw != 8'h00) ? 32'd1 : 32'd0);
      @(negedge clk);
      chk("ack_go_single", 32'(go), 32'd0);
   endtask

   task automatic pulse_reset();
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic clear_done();
      int g0;
      g0 = go_cnt;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("clr_count", 32'(hash_count), 32'd0);
      chk("clr_found", 32'(found), 32'd0);
      chk("clr_error", 32'(error), 32'd0);
      @(negedge clk);
      chk("clr_ready", 32'(host_ready), 32'd1);
      chk("clr_no_go", 32'(go_cnt), 32'(g0));
   endtask

   initial begin
      int g0, s0, w;
      for (int i = 0; i < 16; i++) begin
         tbl[i].data      = 8'(i);
         tbl[i].exp_count = (i == 15) ? 8'd1 : 8'd0;
      end

      #12;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_go", 32'(go), 32'd0);
      chk("rst_rv", 32'(result_valid), 32'd0);
      chk("rst_count", 32'(hash_count), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", 32'(host_ready), 32'd1);

      // one hash, then "ab\0"
      gap_err = 0; last_strobe = -1; s0 = strobe_cnt;
      load_table();
      chk("strobes_16", 32'(strobe_cnt - s0), 32'd16);
      chk("strobe_spacing", 32'(gap_err), 32'd0);
      rv_cnt = 0;
      launch();
      emit_one(8'h61);
      emit_one(8'h62);
      emit_one(8'h00);
      chk("done_found", 32'(found), 32'd1);
      chk("done_busy", 32'(busy), 32'd0);
      chk("rv_count", 32'(rv_cnt), 32'd3);
      clear_done();

      // exhausted search
      load_table();
      rv_cnt = 0;
      launch();
      your_turn = 1'b1;
      @(negedge clk);
      your_turn = 1'b0;
      @(negedge clk);
      chk("exh_found", 32'(found), 32'd0);
      chk("exh_busy", 32'(busy), 32'd0);
      @(negedge clk);
      chk("exh_no_rv", 32'(rv_cnt), 32'd0);
      clear_done();

      // partial hash start, then empty-table start
      for (int i = 0; i < 5; i++) put_byte(8'h30 + 8'(i), 8'd0);
      g0 = go_cnt;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("partial_error", 32'(error), 32'd1);
      repeat (3) @(negedge clk);
      chk("partial_no_go", 32'(go_cnt), 32'(g0));
      chk("partial_idle", 32'(busy), 32'd0);
      pulse_reset();
      chk("err_cleared_by_rst", 32'(error), 32'd0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("empty_error", 32'(error), 32'd1);
      repeat (3) @(negedge clk);
      chk("empty_no_go", 32'(go_cnt), 32'(g0));
      pulse_reset();

      // fill the table
      s0 = strobe_cnt;
      host_byte  = 8'hA5;
      host_valid = 1'b1;
      w = 0;
      while (hash_count != 8'd128 && w < 9000) begin
         @(negedge clk);
         w++;
      end
      chk("full_count", 32'(hash_count), 32'd128);
      chk("full_ready_drop", 32'(host_ready), 32'd0);
      chk("full_strobes", 32'(strobe_cnt - s0), 32'd2048);
      repeat (20) @(negedge clk);
      chk("full_no_extra", 32'(strobe_cnt - s0), 32'd2048);
      chk("full_ready_low", 32'(host_ready), 32'd0);
      host_valid = 1'b0;
      pulse_reset();

      // reset during STROBE
      wait_ready();
      host_valid = 1'b1;
      host_byte  = 8'h77;
      @(negedge clk);
      host_valid = 1'b0;
      @(negedge clk);
      chk("pre_rst_strobe", 32'(store_hash_byte), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("rst_strobe_low", 32'(store_hash_byte), 32'd0);
      chk("rst_byte_zero", 32'(new_hash_byte), 32'd0);
      chk("rst_busy_low", 32'(busy), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      load_table();

      // reset during EMIT with host stalled
      launch();
      result_ready  = 1'b0;
      your_turn     = 1'b1;
      match_found   = 1'b1;
      password_byte = 8'h41;
      @(negedge clk);
      your_turn   = 1'b0;
      match_found = 1'b0;
      repeat (3) @(negedge clk);
      chk("stall_rv", 32'(result_valid), 32'd1);
      chk("stall_byte", 32'(result_byte), 32'h41);
      #2 reset_n = 1'b0;
      #1;
      chk("rst_emit_rv", 32'(result_valid), 32'd0);
      chk("rst_emit_byte", 32'(result_byte), 32'd0);
      chk("rst_emit_count", 32'(hash_count), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      result_ready = 1'b1;
      @(negedge clk);
      load_table();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
